// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped instruction cache. One-cycle hits; a miss fills
//               the whole 16-byte line with four word reads through the
//               memory controller, then returns the requested instruction.
//               Honours the global rdy stall and the rollback flush.
// Revision    : 1.0 - initial release
// ============================================================================
module icache #(
    parameter int INDEX_BITS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              ic_ready,
    output logic              ic_valid,
    output logic [31:0]       ic_inst,
    output logic [ADDR_W-1:0] ic_pc,
    output logic              mc_req,
    output logic [ADDR_W-1:0] mc_addr,
    input  logic              mc_done,
    input  logic [31:0]       mc_data
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - 4 - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [0:LINES-1];
    logic [31:0]           r_data [0:LINES*4-1];
    logic [ADDR_W-1:0]     r_pc;
    logic [1:0]            r_fill_cnt;
    logic                  r_discard;

    // Request-side address split and lookup
    logic [INDEX_BITS-1:0] w_req_idx;
    logic [TAG_W-1:0]      w_req_tag;
    logic [1:0]            w_req_off;
    logic                  w_hit;
    logic [31:0]           w_hit_word;

    // Fill-side address split (from the latched miss PC)
    logic [INDEX_BITS-1:0] w_fill_idx;
    logic [TAG_W-1:0]      w_fill_tag;
    logic                  w_fill_we;
    logic [31:0]           w_resp_word;

    // Byte-offset bits of the fetch PC carry no information for word fetches
    logic                  w_unused;

    assign w_req_idx  = if_pc[4+INDEX_BITS-1:4];
    assign w_req_tag  = if_pc[ADDR_W-1:4+INDEX_BITS];
    assign w_req_off  = if_pc[3:2];
    assign w_hit      = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_hit_word = r_data[{w_req_idx, w_req_off}];

    assign w_fill_idx = r_pc[4+INDEX_BITS-1:4];
    assign w_fill_tag = r_pc[ADDR_W-1:4+INDEX_BITS];
    assign w_fill_we  = rdy && (r_state == S_FILL) && mc_done;
    // The last fill word is written on the edge that enters RESP, so the
    // array already holds it here and no bypass path is needed.
    assign w_resp_word = r_data[{w_fill_idx, r_pc[3:2]}];

    assign ic_ready = (r_state == S_IDLE);
    assign w_unused = &{1'b0, if_pc[1:0]};

    // Line data and tag storage: written only while filling, never reset
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[{w_fill_idx, r_fill_cnt}] <= mc_data;
            if (r_fill_cnt == 2'd3) begin
                r_tag[w_fill_idx] <= w_fill_tag;
            end
        end
    end

    // Control FSM: lookup, line fill sequencing, response and flush handling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_pc       <= '0;
            r_fill_cnt <= 2'd0;
            r_discard  <= 1'b0;
            ic_valid   <= 1'b0;
            ic_inst    <= 32'd0;
            ic_pc      <= '0;
            mc_req     <= 1'b0;
            mc_addr    <= '0;
        end else if (rdy) begin
            ic_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_discard <= 1'b0;
                    if (if_valid && !rollback) begin
                        if (w_hit) begin
                            ic_valid <= 1'b1;
                            ic_inst  <= w_hit_word;
                            ic_pc    <= {if_pc[ADDR_W-1:2], 2'b00};
                        end else begin
                            r_pc               <= {if_pc[ADDR_W-1:2], 2'b00};
                            r_fill_cnt         <= 2'd0;
                            mc_req             <= 1'b1;
                            mc_addr            <= {if_pc[ADDR_W-1:4], 4'b0000};
                            r_valid[w_req_idx] <= 1'b0;
                            r_state            <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    // The memory transaction cannot be aborted; a flush only
                    // suppresses the eventual response.
                    if (rollback) begin
                        r_discard <= 1'b1;
                    end
                    if (mc_done) begin
                        if (r_fill_cnt != 2'd3) begin
                            r_fill_cnt <= r_fill_cnt + 2'd1;
                            mc_addr    <= mc_addr + ADDR_W'(4);
                        end else begin
                            mc_req              <= 1'b0;
                            r_valid[w_fill_idx] <= 1'b1;
                            r_state             <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (!(r_discard || rollback)) begin
                        ic_valid <= 1'b1;
                        ic_inst  <= w_resp_word;
                        ic_pc    <= r_pc;
                    end
                    r_discard <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between the instruction fetcher (upstream) and the memory controller (downstream).
- Hits return an instruction one cycle after the request is accepted.
- Misses fill a whole 16-byte line: four sequential word reads through the memory controller's word-request handshake, then the requested instruction is returned.
- Honours the global `rdy` stall and the pipeline `rollback` flush.

Parameters:
- INDEX_BITS, 4, line index width; line count = 2^INDEX_BITS (default 16 lines x 16 B = 256 B).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rdy  in  1  global ready; when low, all state and outputs freeze.
- rollback  in  1  pipeline flush; pending fetch response is discarded.
- if_valid  in  1  fetch request from the fetcher.
- if_pc  in  ADDR_W  fetch byte address; bits [1:0] are ignored (treated as 0).
- ic_ready  out  1  cache can accept a request this cycle.
- ic_valid  out  1  one-cycle pulse: instruction delivered.
- ic_inst  out  32  instruction word.
- ic_pc  out  ADDR_W  word-aligned PC of the delivered instruction.
- mc_req  out  1  word read request to the memory controller.
- mc_addr  out  ADDR_W  word-aligned read address.
- mc_done  in  1  one-cycle pulse: mc_data valid, request retired.
- mc_data  in  32  little-endian word read.

Behaviour:
- **Address split:** offset = pc[3:2], index = pc[4+INDEX_BITS-1:4], tag = pc[ADDR_W-1:4+INDEX_BITS].
- **Storage:** per line, one valid bit, a tag, and four 32-bit words.
- **Reset (async):**
  - All valid bits cleared; state = IDLE.
  - ic_valid=0, ic_inst=0, ic_pc=0, mc_req=0, mc_addr=0.
  - ic_ready=1 once state is IDLE.
  - Data/tag arrays need not be reset.
- **rdy low:** no register changes (including fill counter and valid bits); mc_done/if_valid are ignored that cycle.
- **ic_ready:** 1 only in IDLE.
- **ic_valid:** defaults to 0 every active cycle unless set below.
- **State IDLE:**
  - if_valid && !rollback, hit (valid && tag match): next cycle ic_valid=1, ic_inst=line word[offset], ic_pc={if_pc[ADDR_W-1:2],2'b0}; stay IDLE. Back-to-back hits sustain one instruction per cycle.
  - if_valid && !rollback, miss: latch pc; set fill_cnt=0, mc_req=1, mc_addr={tag,index,2'b00,2'b00}; go to FILL; clear the line's valid bit.
  - rollback asserted: any request in the same cycle is ignored.
- **State FILL:**
  - mc_req is held high with a stable mc_addr until mc_done.
  - On mc_done: write mc_data into word[fill_cnt].
    - fill_cnt<3: fill_cnt+1; mc_addr+4; mc_req stays 1 (no idle gap required).
    - fill_cnt==3: mc_req=0; set valid and tag for the line; go to RESP.
- **State RESP:**
  - Next cycle: ic_valid=1 with the latched pc's word, unless discarded; return to IDLE.
  - The word is taken from the just-filled line, or forwarded if the write is not yet visible.
- **Rollback during FILL or RESP:** the fill always completes and the line becomes valid, because the memory controller transaction cannot be aborted. A discard flag is set and the pending response is suppressed (no ic_valid pulse). The discard flag clears on return to IDLE.
- **Rollback in the cycle ic_valid would be issued from IDLE hit:** the request was not accepted, so no pulse.
- **mc_done outside FILL:** ignored.
- **Latency (rdy high, memctrl W cycles/word):**
  - Hit: 1 cycle request->ic_valid.
  - Miss: 1 + 4W + 1 cycles.
- **No self-modifying code support:** stores do not invalidate lines.

Test Plan:
- **Reset then cold miss:** rst pulse, if_pc=0x0000_0100, memory words 0x100..0x10C = 0x11,0x22,0x33,0x44.
  - Exactly 4 mc_req transactions at 0x100,0x104,0x108,0x10C.
  - One ic_valid with ic_inst=0x11, ic_pc=0x100.
  - ic_ready=0 throughout.
- **Hit streak:** after the fill above, requests 0x104,0x108,0x10C on consecutive cycles.
  - ic_valid on 3 consecutive cycles with 0x22,0x33,0x44.
  - mc_req stays 0.
- **Conflict eviction:** request 0x200 (same index 0, different tag) -> fill at 0x200..0x20C. A following request to 0x100 -> miss, refill from 0x100.
- **Rollback mid-fill:** request 0x300 miss, rollback pulse after the 2nd mc_done.
  - Remaining 2 words still fetched; no ic_valid.
  - Subsequent request 0x304 hits in 1 cycle.
- **rdy stall:** rdy=0 for 5 cycles during FILL, with mc_done asserted while stalled.
  - fill_cnt, mc_addr, and outputs are unchanged.
  - Final data is correct and delivered exactly once.
- **Async reset mid-FILL:** assert rst between clock edges.
  - mc_req drops immediately; ic_ready=1 after release.
  - Re-request of the same pc misses, because the valid bit was cleared.
